cpri_tx_framer: RTL and testbench
=================================

Name: cpri_tx_framer

Overview:
- Transmit-side CPRI framer feeding o_cpri_tx_data/o_cpri_tx_vld of pusch_dr_top.
- Packs compressed beam payload words into fixed 96-word CPRI frames:
  - sync and control words, a latched header, two RB-AGC words, then payload.
- Frame word layout matches the layout the UL receive path parses (header at seq 3, AGC at seq 5/6), so lanes loop back cleanly in simulation.
- Frames start on the i_iq_tx_enable strobe, which pulses once every 96 cycles.

Parameters:
- FRAME_WORDS, 96, words per CPRI frame (seq 0..FRAME_WORDS-1).
- DW, 64, CPRI word width.
- PLD_START, 7, first payload seq index.
- SYNC_WORD, 16'h50BC, pattern in word 0 bits [63:48].

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_iq_tx_enable  in  1  frame-start strobe.
- i_hdr  in  64  frame header; sampled when a start is accepted.
- i_agc0  in  64  RB-AGC word 0; sampled when a start is accepted.
- i_agc1  in  64  RB-AGC word 1; sampled when a start is accepted.
- i_pld_data  in  64  payload word.
- i_pld_vld  in  1  payload valid.
- o_pld_rdy  out  1  payload ready; a word is consumed when i_pld_vld & o_pld_rdy.
- o_cpri_tx_data  out  64  CPRI word, registered.
- o_cpri_tx_vld  out  1  first-word marker; high only on seq 0.
- o_cpri_tx_seq  out  7  seq index of the word on o_cpri_tx_data.
- o_busy  out  1  a frame is in progress.
- o_underflow  out  1  one-cycle pulse when a payload slot is zero-filled.
- o_sync_err  out  1  one-cycle pulse when a start strobe is ignored.
- o_frame_cnt  out  8  frames started, wraps at 255.

Behaviour:
- Reset values: all outputs 0; state IDLE; seq 0; latched header and AGC 0; frame counter 0. Reset asserted mid-frame aborts the frame at the next edge, with no partial flush.
- States:
  - IDLE: no frame; o_busy=0.
  - CTRL: seq 0..PLD_START-1.
  - PLD: seq PLD_START..95.
- Start acceptance:
  - A strobe is accepted in IDLE, or in PLD when the current output seq==95 (back-to-back frames).
  - On acceptance: latch i_hdr/i_agc0/i_agc1, increment o_frame_cnt, emit word 0 on the next edge. Latency from strobe to o_cpri_tx_vld is 1 cycle.
  - A strobe at any other time is ignored and o_sync_err pulses.
- Word contents:
  - seq0 = {SYNC_WORD, 40'h0, frame_cnt}, where frame_cnt is the post-increment value.
  - seq1, seq2, seq4 = 0.
  - seq3 = latched header.
  - seq5 = agc0; seq6 = agc1.
  - seq PLD_START..95 = payload.
- Payload handshake:
  - o_pld_rdy is combinational. It is high when the next emitted seq is a payload slot, i.e. the current seq is in PLD_START-1..94 while busy.
  - A consumed word appears on o_cpri_tx_data at the next edge.
  - If rdy=1 and vld=0, the slot is emitted as 0 and o_underflow pulses with that word.
  - vld is ignored while rdy=0, and no data is consumed.
- End of frame:
  - After seq 95 with no start strobe, return to IDLE. o_cpri_tx_data goes to 0, o_busy to 0, o_cpri_tx_seq to 0.
  - Back-to-back: seq 95 is followed directly by seq 0 with no gap.
- o_cpri_tx_seq increments by 1 per cycle while busy; no skips, no stalls.
- Simultaneous start strobe and reset: reset wins.

Optional Feature:
- Macro: CPRI_TX_CHKSUM_EN.
- Defined:
  - Payload occupies seq 7..94 (88 words).
  - seq 95 carries the XOR of all 88 emitted payload words, zero-filled words included.
  - o_pld_rdy is low for the seq 95 slot.
  - The accumulator clears at each accepted start.
- Undefined: payload occupies seq 7..95 (89 words); no checksum logic is present.

Decomposition:
- Shared package (params_list_pkg): FRAME_WORDS, PLD_START, SYNC_WORD, the seq index constants (HDR_SEQ=3, AGC0_SEQ=5, AGC1_SEQ=6), and a typedef enum for the states {IDLE, CTRL, PLD}.
- Optional sub-module cpri_tx_seq_ctrl: the state machine, seq counter, start acceptance and rdy generation. The top level keeps only word muxing, the latches and the checksum.

Test Plan:
- Reset release, then strobe at cycle 10 with i_hdr=64'hA5, agc0=1, agc1=2, payload always valid counting from 1:
  - vld high only at cycle 11.
  - seq0 = 64'h50BC_0000_0000_0001.
  - seq3=A5, seq5=1, seq6=2.
  - seq7=1 … seq95=89 (without the macro).
- Strobe every 96 cycles, 4 frames: contiguous output, seq 95→0 with no gap; o_frame_cnt=4; no o_sync_err.
- Mid-frame strobe at seq 40: ignored; o_sync_err pulses once; the frame continues unchanged to seq 95.
- Payload vld dropped for seq 20..22:
  - those words are 0 with o_underflow high for 3 cycles;
  - payload resumes at seq 23 with the next unconsumed value;
  - no words are lost from the source.
- i_reset asserted at seq 50 for 1 cycle: all outputs 0 next cycle; a new strobe restarts with frame_cnt=1.
- With CPRI_TX_CHKSUM_EN and payload 1..88: seq 95 = XOR(1..88) = 64'h58; o_pld_rdy low at that slot.

Source files
------------

// File: rtl/cpri_tx_framer_pkg.sv
// Shared constants and state type for the CPRI transmit framer.
// CPRI_TX_CHKSUM_EN moves the last payload slot to 94 and puts a checksum in slot 95.
package params_list_pkg;
  localparam int              FRAME_WORDS = 96;
  localparam int              DW          = 64;
  localparam logic [6:0]      PLD_START   = 7'd7;
  localparam logic [6:0]      LAST_SEQ    = 7'(FRAME_WORDS - 1);
  localparam logic [6:0]      RDY_FIRST   = PLD_START - 7'd1;
  localparam logic [15:0]     SYNC_WORD   = 16'h50BC;
  localparam logic [6:0]      HDR_SEQ     = 7'd3;
  localparam logic [6:0]      AGC0_SEQ    = 7'd5;
  localparam logic [6:0]      AGC1_SEQ    = 7'd6;
`ifdef CPRI_TX_CHKSUM_EN
  localparam logic [6:0]      PLD_LAST    = 7'd94;
`else
  localparam logic [6:0]      PLD_LAST    = 7'd95;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CTRL = 2'd1,
    PLD  = 2'd2
  } state_t;
endpackage

// File: rtl/cpri_tx_framer_if.sv
// Payload stream and CPRI word output of the transmit framer.
interface cpri_tx_framer_if;
  import params_list_pkg::*;

  logic [DW-1:0] i_pld_data;
  logic          i_pld_vld;
  logic          o_pld_rdy;
  logic [DW-1:0] o_cpri_tx_data;
  logic          o_cpri_tx_vld;
  logic [6:0]    o_cpri_tx_seq;

  modport master (
    output i_pld_data, i_pld_vld,
    input  o_pld_rdy, o_cpri_tx_data, o_cpri_tx_vld, o_cpri_tx_seq
  );

  modport slave (
    input  i_pld_data, i_pld_vld,
    output o_pld_rdy, o_cpri_tx_data, o_cpri_tx_vld, o_cpri_tx_seq
  );
endinterface

// File: rtl/cpri_tx_framer_seq_ctrl.sv
// Frame state machine: seq counter, start acceptance, payload-ready and frame count.
// CPRI_TX_CHKSUM_EN (via the package) withholds ready for slot 95.
module cpri_tx_seq_ctrl
  import params_list_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_iq_tx_enable,
  output logic       start_s,
  output logic [6:0] seq_nxt_s,
  output logic       busy_nxt_s,
  output logic [6:0] seq_r,
  output logic       busy_r,
  output logic       pld_rdy_s,
  output logic       sync_err_r,
  output logic [7:0] frame_cnt_r,
  output logic [7:0] frame_cnt_nxt_s
);
  state_t state_r;
  state_t state_nxt_s;

  // Next-state and next-seq decode; a start is only legal when idle or on the last word
  always_comb begin
    state_nxt_s = state_r;
    seq_nxt_s   = seq_r;
    start_s     = i_iq_tx_enable &&
                  ((state_r == IDLE) || ((state_r == PLD) && (seq_r == LAST_SEQ)));
    case (state_r)
      IDLE: begin
        seq_nxt_s   = 7'd0;
        state_nxt_s = start_s ? CTRL : IDLE;
      end
      CTRL: begin
        seq_nxt_s   = seq_r + 7'd1;
        state_nxt_s = (seq_r == RDY_FIRST) ? PLD : CTRL;
      end
      PLD: begin
        if (seq_r == LAST_SEQ) begin
          seq_nxt_s   = 7'd0;
          state_nxt_s = start_s ? CTRL : IDLE;
        end else begin
          seq_nxt_s   = seq_r + 7'd1;
          state_nxt_s = PLD;
        end
      end
      default: begin
        seq_nxt_s   = 7'd0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign busy_nxt_s      = (state_nxt_s != IDLE);
  assign frame_cnt_nxt_s = start_s ? (frame_cnt_r + 8'd1) : frame_cnt_r;
  // Ready is withheld during reset so no source word is lost to an aborted frame
  assign pld_rdy_s       = !i_reset && (state_r != IDLE) &&
                           (seq_r >= RDY_FIRST) && (seq_r < PLD_LAST);

  // State, seq and status registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= IDLE;
      seq_r       <= 7'd0;
      busy_r      <= 1'b0;
      sync_err_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      seq_r       <= seq_nxt_s;
      busy_r      <= busy_nxt_s;
      sync_err_r  <= i_iq_tx_enable && !start_s;
      frame_cnt_r <= frame_cnt_nxt_s;
    end
  end
endmodule

// File: rtl/cpri_tx_framer.sv
// CPRI transmit framer top: header/AGC latches, word mux and registered CPRI output.
// Define CPRI_TX_CHKSUM_EN to carry an XOR checksum of the payload in slot 95.
module cpri_tx_framer
  import params_list_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_iq_tx_enable,
  input  logic [DW-1:0]       i_hdr,
  input  logic [DW-1:0]       i_agc0,
  input  logic [DW-1:0]       i_agc1,
  cpri_tx_framer_if.slave     bus,
  output logic                o_busy,
  output logic                o_underflow,
  output logic                o_sync_err,
  output logic [7:0]          o_frame_cnt
);
  logic          start_s;
  logic          busy_nxt_s;
  logic          busy_r;
  logic          pld_rdy_s;
  logic          sync_err_r;
  logic [6:0]    seq_nxt_s;
  logic [6:0]    seq_r;
  logic [7:0]    frame_cnt_r;
  logic [7:0]    frame_cnt_nxt_s;
  logic [DW-1:0] hdr_r;
  logic [DW-1:0] agc0_r;
  logic [DW-1:0] agc1_r;
  logic [DW-1:0] pld_word_s;
  logic [DW-1:0] data_nxt_s;
  logic [DW-1:0] data_r;
  logic          underflow_nxt_s;
  logic          underflow_r;
  logic          vld_r;
`ifdef CPRI_TX_CHKSUM_EN
  logic [DW-1:0] csum_r;
`endif

  cpri_tx_seq_ctrl u_seq_ctrl (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_iq_tx_enable  (i_iq_tx_enable),
    .start_s         (start_s),
    .seq_nxt_s       (seq_nxt_s),
    .busy_nxt_s      (busy_nxt_s),
    .seq_r           (seq_r),
    .busy_r          (busy_r),
    .pld_rdy_s       (pld_rdy_s),
    .sync_err_r      (sync_err_r),
    .frame_cnt_r     (frame_cnt_r),
    .frame_cnt_nxt_s (frame_cnt_nxt_s)
  );

  assign pld_word_s    = bus.i_pld_vld ? bus.i_pld_data : {DW{1'b0}};
  assign bus.o_pld_rdy = pld_rdy_s;

  // Select the word for the slot emitted at the next edge
  always_comb begin
    data_nxt_s      = {DW{1'b0}};
    underflow_nxt_s = 1'b0;
    if (start_s) begin
      data_nxt_s = {SYNC_WORD, 40'h0, frame_cnt_nxt_s};
    end else if (pld_rdy_s) begin
      data_nxt_s      = pld_word_s;
      underflow_nxt_s = !bus.i_pld_vld;
    end else if (busy_nxt_s) begin
      case (seq_nxt_s)
        HDR_SEQ:  data_nxt_s = hdr_r;
        AGC0_SEQ: data_nxt_s = agc0_r;
        AGC1_SEQ: data_nxt_s = agc1_r;
`ifdef CPRI_TX_CHKSUM_EN
        LAST_SEQ: data_nxt_s = csum_r;
`endif
        default:  data_nxt_s = {DW{1'b0}};
      endcase
    end else begin
      data_nxt_s = {DW{1'b0}};
    end
  end

  // Output word register and per-frame latches
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_r      <= {DW{1'b0}};
      vld_r       <= 1'b0;
      underflow_r <= 1'b0;
      hdr_r       <= {DW{1'b0}};
      agc0_r      <= {DW{1'b0}};
      agc1_r      <= {DW{1'b0}};
    end else begin
      data_r      <= data_nxt_s;
      vld_r       <= start_s;
      underflow_r <= underflow_nxt_s;
      if (start_s) begin
        hdr_r  <= i_hdr;
        agc0_r <= i_agc0;
        agc1_r <= i_agc1;
      end
    end
  end

`ifdef CPRI_TX_CHKSUM_EN
  // Running XOR of every emitted payload slot, zero-filled ones included
  always_ff @(posedge i_clk) begin
    if (i_reset || start_s) begin
      csum_r <= {DW{1'b0}};
    end else if (pld_rdy_s) begin
      csum_r <= csum_r ^ pld_word_s;
    end
  end
`endif

  assign bus.o_cpri_tx_data = data_r;
  assign bus.o_cpri_tx_vld  = vld_r;
  assign bus.o_cpri_tx_seq  = seq_r;
  assign o_busy             = busy_r;
  assign o_underflow        = underflow_r;
  assign o_sync_err         = sync_err_r;
  assign o_frame_cnt        = frame_cnt_r;
endmodule

// File: tb/tb_cpri_tx_framer.sv
// Self-checking bench for cpri_tx_framer: word-position reference model, frame table, directed corners, random traffic.
module tb_cpri_tx_framer;
`ifdef CPRI_TX_CHKSUM_EN
  localparam int M_LAST = 94;
  localparam logic [63:0] EXP95 = 64'h58;
`else
  localparam int M_LAST = 95;
  localparam logic [63:0] EXP95 = 64'd89;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [63:0] hdr, agc0, agc1;
  logic        o_busy, o_underflow, o_sync_err;
  logic [7:0]  o_frame_cnt;

  always #5 clk = ~clk;

  cpri_tx_framer_if bus ();

  cpri_tx_framer dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_iq_tx_enable (strobe),
    .i_hdr          (hdr),
    .i_agc0         (agc0),
    .i_agc1         (agc1),
    .bus            (bus),
    .o_busy         (o_busy),
    .o_underflow    (o_underflow),
    .o_sync_err     (o_sync_err),
    .o_frame_cnt    (o_frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // reference model: frame position (-1 = idle) plus latched fields
  int          m_pos = -1;
  logic [7:0]  m_cnt;
  logic [63:0] m_hdr, m_agc0, m_agc1, m_csum;
  int          src_idx = 0;
  logic [63:0] src_mem [0:4095];
  logic [63:0] e_data;
  bit          e_vld, e_busy, e_und, e_serr;
  int          e_seq;

  logic [63:0] cap [0:95];
  int cyc = 0, vld_cnt = 0, last_vld_cyc = -1;
  int serr_cnt = 0, und_cnt = 0, gap_cnt = 0;

  typedef struct {
    int          seq;
    logic [63:0] data;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_rdy();
    return (reset == 1'b0) && (m_pos >= 6) && (m_pos <= M_LAST - 1);
  endfunction

  task automatic tick();
    logic [63:0] nd;
    bit acc, und, rdy;
    bus.i_pld_data = src_mem[src_idx];
    #2;
    rdy = m_rdy();
    chk("pld_rdy", 64'(bus.o_pld_rdy), 64'(rdy));
    nd = 64'h0; und = 1'b0; acc = 1'b0;
    e_serr = 1'b0;
    if (reset) begin
      m_pos = -1; m_cnt = 8'd0; m_hdr = 64'h0; m_agc0 = 64'h0; m_agc1 = 64'h0; m_csum = 64'h0;
    end else begin
      acc = strobe && (m_pos < 0 || m_pos == 95);
      e_serr = strobe && !acc;
      if (acc) begin
        m_pos = 0; m_cnt = m_cnt + 8'd1;
        m_hdr = hdr; m_agc0 = agc0; m_agc1 = agc1; m_csum = 64'h0;
        nd = {16'h50BC, 40'h0, m_cnt};
      end else if (m_pos < 0 || m_pos == 95) begin
        m_pos = -1;
      end else begin
        m_pos++;
        if (m_pos == 3) nd = m_hdr;
        else if (m_pos == 5) nd = m_agc0;
        else if (m_pos == 6) nd = m_agc1;
        else if (m_pos >= 7 && m_pos <= M_LAST) begin
          if (bus.i_pld_vld) begin
            nd = src_mem[src_idx];
            src_idx = (src_idx + 1) % 4096;
          end else begin
            und = 1'b1;
          end
          m_csum = m_csum ^ nd;
        end else if (m_pos == 95) nd = m_csum;
      end
    end
    e_data = nd; e_vld = acc; e_und = und;
    e_seq  = (m_pos < 0) ? 0 : m_pos;
    e_busy = (m_pos >= 0);
    @(posedge clk);
    cyc++;
    #1;
    chk("data", bus.o_cpri_tx_data, e_data);
    chk("vld", 64'(bus.o_cpri_tx_vld), 64'(e_vld));
    chk("seq", 64'(bus.o_cpri_tx_seq), 64'(e_seq));
    chk("busy", 64'(o_busy), 64'(e_busy));
    chk("underflow", 64'(o_underflow), 64'(e_und));
    chk("sync_err", 64'(o_sync_err), 64'(e_serr));
    chk("frame_cnt", 64'(o_frame_cnt), 64'(m_cnt));
    if (m_pos >= 0) cap[m_pos] = bus.o_cpri_tx_data;
    if (bus.o_cpri_tx_vld) begin vld_cnt++; last_vld_cyc = cyc; end
    if (o_sync_err) serr_cnt++;
    if (o_underflow) und_cnt++;
    if (!o_busy) gap_cnt++;
  endtask

  task automatic run_to(input int p);
    int n = 0;
    while (m_pos != p && n < 300) begin tick(); n++; end
    if (m_pos != p) begin
      checks++; errors++;
      $display("FAIL run_to: position %0d required %0d", m_pos, p);
    end
  endtask

  task automatic start_frame();
    strobe = 1'b1; tick(); strobe = 1'b0;
  endtask

  initial begin
    int strobe_cyc;
    for (int i = 0; i < 4096; i++) src_mem[i] = 64'(i + 1);
    reset = 1'b1; strobe = 1'b0; hdr = 64'h0; agc0 = 64'h0; agc1 = 64'h0;
    bus.i_pld_vld = 1'b0; bus.i_pld_data = 64'h0;
    @(posedge clk); #1;
    repeat (3) tick();
    chk("reset_data", bus.o_cpri_tx_data, 64'h0);
    chk("reset_cnt", 64'(o_frame_cnt), 64'h0);

    // frame 1: strobe at cycle 10, payload counting from 1
    reset = 1'b0; bus.i_pld_vld = 1'b1; cyc = 0; vld_cnt = 0;
    repeat (10) tick();
    hdr = 64'hA5; agc0 = 64'd1; agc1 = 64'd2;
    strobe_cyc = cyc;
    start_frame();
    hdr = {$urandom, $urandom}; agc0 = {$urandom, $urandom}; agc1 = {$urandom, $urandom};
    run_to(95);
    chk("vld_count", 64'(vld_cnt), 64'd1);
    chk("vld_cycle", 64'(last_vld_cyc), 64'(strobe_cyc + 1));
    tbl[0]  = '{0,  64'h50BC_0000_0000_0001};
    tbl[1]  = '{1,  64'h0};
    tbl[2]  = '{2,  64'h0};
    tbl[3]  = '{3,  64'hA5};
    tbl[4]  = '{4,  64'h0};
    tbl[5]  = '{5,  64'd1};
    tbl[6]  = '{6,  64'd2};
    tbl[7]  = '{7,  64'd1};
    tbl[8]  = '{50, 64'd44};
    tbl[9]  = '{94, 64'd88};
    tbl[10] = '{95, EXP95};
    for (int i = 0; i < 11; i++) chk($sformatf("frame1_seq%0d", tbl[i].seq), cap[tbl[i].seq], tbl[i].data);

    // three more back-to-back frames
    serr_cnt = 0; gap_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      run_to(95);
    end
    chk("b2b_frame_cnt", 64'(o_frame_cnt), 64'd4);
    chk("b2b_sync_err", 64'(serr_cnt), 64'd0);
    chk("b2b_gaps", 64'(gap_cnt), 64'd0);
    tick();
    chk("idle_busy", 64'(o_busy), 64'd0);

    // ignored mid-frame strobe
    serr_cnt = 0;
    start_frame();
    run_to(40);
    start_frame();
    run_to(95);
    chk("mid_sync_err", 64'(serr_cnt), 64'd1);
    chk("mid_frame_cnt", 64'(o_frame_cnt), 64'd5);
    tick();

    // underflow on slots 20..22
    und_cnt = 0;
    start_frame();
    run_to(19);
    bus.i_pld_vld = 1'b0;
    repeat (3) tick();
    bus.i_pld_vld = 1'b1;
    run_to(95);
    chk("und_count", 64'(und_cnt), 64'd3);
    for (int s = 20; s <= 22; s++) chk($sformatf("und_zero%0d", s), cap[s], 64'h0);
    chk("und_resume", cap[23], cap[19] + 64'd1);
    tick();

    // reset at seq 50, then restart
    start_frame();
    run_to(50);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_seq", 64'(bus.o_cpri_tx_seq), 64'd0);
    start_frame();
    chk("rst_restart_w0", bus.o_cpri_tx_data, 64'h50BC_0000_0000_0001);
    run_to(95);
    tick();

    // randomized traffic
    for (int i = 0; i < 4096; i++) src_mem[i] = {$urandom, $urandom};
    for (int n = 0; n < 3000; n++) begin
      strobe = (m_pos == 95) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
      bus.i_pld_vld = ($urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 599) == 0);
      hdr = {$urandom, $urandom}; agc0 = {$urandom, $urandom}; agc1 = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
